// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter types and constants
package uart_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: parallel request side and serial line of the UART transmitter
interface uart_tx_if #(parameter int DATA_WIDTH = uart_pkg::DEF_DATA_WIDTH);
  logic [DATA_WIDTH-1:0] i_data;
  logic i_data_valid;
  logic i_par_en;
  logic i_par_typ;
  logic o_ready;
  logic o_tx_out;
  logic o_busy;
  modport master (output i_data, i_data_valid, i_par_en, i_par_typ, input o_ready, o_tx_out, o_busy);
  modport slave (input i_data, i_data_valid, i_par_en, i_par_typ, output o_ready, o_tx_out, o_busy);
endinterface

// File: rtl/uart_parity_calc.sv
// uart_parity_calc: parity bit of the captured payload, even or odd
module uart_parity_calc import uart_pkg::*; #(parameter int DATA_WIDTH = DEF_DATA_WIDTH) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par
);
  assign par = (^data) ^ (par_typ == PAR_ODD);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: one bit per clock serialiser with start, optional parity and stop bits
module uart_tx import uart_pkg::*; #(parameter int DATA_WIDTH = DEF_DATA_WIDTH) (
  input logic     i_clk,
  input logic     i_rst,
  uart_tx_if.slave bus
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] data_q;
  logic par_en_q, par_typ_q, par, tx, accept;
  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data(data_q),
    .par_typ(par_typ_q),
    .par(par)
  );
  assign bus.o_ready = (state == IDLE) || (state == STOP);
  assign bus.o_busy = state != IDLE;
  assign bus.o_tx_out = tx;
  assign accept = bus.i_data_valid && bus.o_ready;
  // frame sequencing; the line bit is registered alongside the state it belongs to
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      tx <= 1'b1;
      cnt <= '0;
      data_q <= '0;
      par_en_q <= 1'b0;
      par_typ_q <= PAR_EVEN;
    end else begin
      case (state)
        IDLE, STOP: begin
          if (accept) begin
            state <= START;
            tx <= 1'b0;
            data_q <= bus.i_data;
            par_en_q <= bus.i_par_en;
            par_typ_q <= bus.i_par_typ;
          end else begin
            state <= IDLE;
            tx <= 1'b1;
          end
        end
        START: begin
          state <= DATA;
          cnt <= '0;
          tx <= data_q[0];
        end
        DATA: begin
          if (cnt == LAST) begin
            state <= par_en_q ? PARITY : STOP;
            tx <= par_en_q ? par : 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            tx <= data_q[cnt + 1'b1];
          end
        end
        PARITY: begin
          state <= STOP;
          tx <= 1'b1;
        end
        default: begin
          state <= IDLE;
          tx <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed frame checks against a line-level model
module tb_uart_tx;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  bit obs_tx[$];
  bit obs_busy[$];
  bit obs_ready[$];
  bit exp_q[$];

  uart_tx_if #(.DATA_WIDTH(DW)) bus ();
  uart_tx #(.DATA_WIDTH(DW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // expected line bits for one frame: start, payload LSB first, optional parity, stop
  function automatic void model(input logic [DW-1:0] d, input bit pe, input bit pt);
    int ones;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) exp_q.push_back(((ones % 2) == 1) != pt);
    exp_q.push_back(1'b1);
  endfunction

  task automatic clear_all();
    obs_tx.delete();
    obs_busy.delete();
    obs_ready.delete();
    exp_q.delete();
  endtask

  task automatic capture(input int n);
    repeat (n) begin
      @(negedge clk);
      obs_tx.push_back(bus.o_tx_out);
      obs_busy.push_back(bus.o_busy);
      obs_ready.push_back(bus.o_ready);
    end
  endtask

  task automatic start_frame(input logic [DW-1:0] d, input bit pe, input bit pt);
    @(negedge clk);
    bus.i_data = d;
    bus.i_par_en = pe;
    bus.i_par_typ = pt;
    bus.i_data_valid = 1'b1;
    @(posedge clk);
    #1 bus.i_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_data_valid = 1'b1;
    bus.i_data = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.o_tx_out, bus.o_busy, bus.o_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL reset_state: tx/busy/ready=%b required 101", {bus.o_tx_out, bus.o_busy, bus.o_ready});
    end
    bus.i_data_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.o_tx_out, bus.o_busy, bus.o_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL reset_release_idle: tx/busy/ready=%b required 101", {bus.o_tx_out, bus.o_busy, bus.o_ready});
    end
  endtask

  task automatic test_basic_a5();
    clear_all();
    model(8'hA5, 1'b0, 1'b0);
    start_frame(8'hA5, 1'b0, 1'b0);
    capture(11);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (obs_tx[i] !== exp_q[i] || obs_busy[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL a5_cycle%0d: tx=%b busy=%b required tx=%b busy=1", i, obs_tx[i], obs_busy[i], exp_q[i]);
      end
    end
    n_checks++;
    if (obs_tx[10] !== 1'b1 || obs_busy[10] !== 1'b0) begin
      n_fail++;
      $display("FAIL a5_idle_after: tx=%b busy=%b required tx=1 busy=0", obs_tx[10], obs_busy[10]);
    end
  endtask

  task automatic test_parity();
    logic [DW-1:0] d[3] = '{8'hA5, 8'hA5, 8'h01};
    bit pt[3] = '{1'b0, 1'b1, 1'b1};
    bit pbit[3] = '{1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 3; c++) begin
      clear_all();
      model(d[c], 1'b1, pt[c]);
      start_frame(d[c], 1'b1, pt[c]);
      capture(12);
      n_checks++;
      if (obs_tx[9] !== pbit[c]) begin
        n_fail++;
        $display("FAIL parity_bit_case%0d: got %b required %b", c, obs_tx[9], pbit[c]);
      end
      for (int i = 0; i < 11; i++) begin
        n_checks++;
        if (obs_tx[i] !== exp_q[i] || obs_busy[i] !== 1'b1) begin
          n_fail++;
          $display("FAIL parity_case%0d_cycle%0d: tx=%b busy=%b required tx=%b busy=1", c, i, obs_tx[i], obs_busy[i], exp_q[i]);
        end
      end
      n_checks++;
      if (obs_busy[11] !== 1'b0 || obs_tx[11] !== 1'b1) begin
        n_fail++;
        $display("FAIL parity_case%0d_len: busy=%b tx=%b at cycle 11 required busy=0 tx=1", c, obs_busy[11], obs_tx[11]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_all();
    model(8'h00, 1'b0, 1'b0);
    model(8'hFF, 1'b0, 1'b0);
    exp_q.push_back(1'b1);
    @(negedge clk);
    bus.i_data = 8'h00;
    bus.i_par_en = 1'b0;
    bus.i_data_valid = 1'b1;
    @(posedge clk);
    #1 bus.i_data = 8'hFF;
    for (int i = 0; i < 21; i++) begin
      capture(1);
      if (i == 10) bus.i_data_valid = 1'b0;
    end
    for (int i = 0; i < 21; i++) begin
      n_checks++;
      if (obs_tx[i] !== exp_q[i] || obs_busy[i] !== (i < 20) || obs_ready[i] !== (i == 9 || i == 19 || i == 20)) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: tx=%b busy=%b ready=%b required tx=%b busy=%b ready=%b", i, obs_tx[i], obs_busy[i], obs_ready[i], exp_q[i], i < 20, i == 9 || i == 19 || i == 20);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_all();
    model(8'h3C, 1'b0, 1'b0);
    start_frame(8'h3C, 1'b0, 1'b0);
    capture(5);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (obs_tx[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rstmid_pre_cycle%0d: tx=%b required %b", i, obs_tx[i], exp_q[i]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus.o_tx_out !== 1'b1 || bus.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_abandon: tx=%b busy=%b required tx=1 busy=0", bus.o_tx_out, bus.o_busy);
    end
    rst = 1'b0;
    clear_all();
    model(8'hC3, 1'b0, 1'b0);
    start_frame(8'hC3, 1'b0, 1'b0);
    capture(10);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (obs_tx[i] !== exp_q[i] || obs_busy[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL rstmid_c3_cycle%0d: tx=%b busy=%b required tx=%b busy=1", i, obs_tx[i], obs_busy[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    clear_all();
    model(8'h55, 1'b0, 1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    start_frame(8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      capture(1);
      if (i == 3) begin
        bus.i_data = 8'hFF;
        bus.i_par_en = 1'b1;
        bus.i_data_valid = 1'b1;
      end
      if (i == 4) bus.i_data_valid = 1'b0;
    end
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (obs_tx[i] !== exp_q[i] || obs_busy[i] !== (i < 10)) begin
        n_fail++;
        $display("FAIL ignore_cycle%0d: tx=%b busy=%b required tx=%b busy=%b", i, obs_tx[i], obs_busy[i], exp_q[i], i < 10);
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    bit pe, pt;
    int len;
    for (int f = 0; f < 24; f++) begin
      d = DW'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      len = DW + 2 + int'(pe);
      clear_all();
      model(d, pe, pt);
      exp_q.push_back(1'b1);
      start_frame(d, pe, pt);
      bus.i_data = DW'($urandom);
      bus.i_par_en = 1'($urandom);
      bus.i_par_typ = 1'($urandom);
      capture(len + 1);
      for (int i = 0; i <= len; i++) begin
        n_checks++;
        if (obs_tx[i] !== exp_q[i] || obs_busy[i] !== (i < len)) begin
          n_fail++;
          $display("FAIL rand%0d_cycle%0d d=%h pe=%b pt=%b: tx=%b busy=%b required tx=%b busy=%b", f, i, d, pe, pt, obs_tx[i], obs_busy[i], exp_q[i], i < len);
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    bus.i_data = '0;
    bus.i_data_valid = 1'b0;
    bus.i_par_en = 1'b0;
    bus.i_par_typ = 1'b0;
    test_reset();
    test_basic_a5();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_ignore_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
